// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the write-only I2C responder.
// FSM encoding, host register map and STATUS bit positions.
package i2c_slave_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_ADDR_ACK,
      S_DATA,
      S_DATA_ACK,
      S_IGNORE
   } state_t;

   localparam logic [1:0] REG_OWN_ADDR = 2'b00;
   localparam logic [1:0] REG_RX_DATA  = 2'b01;
   localparam logic [1:0] REG_STATUS   = 2'b10;
   localparam logic [1:0] REG_CTRL     = 2'b11;

   localparam int STAT_RX_FULL  = 0;
   localparam int STAT_BUSY     = 1;
   localparam int STAT_OVERRUN  = 2;
   localparam int STAT_ADDR_HIT = 3;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus edge, START and STOP detection.
// Flops reset to 1 so a released (idle-high) bus never fakes an event.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_prev;
   logic                   sda_prev;
   logic                   scl_s;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
         scl_prev <= scl_sync[SYNC_STAGES-1];
         sda_prev <= sda_sync[SYNC_STAGES-1];
      end
   end

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_prev;
   assign scl_fall  = ~scl_s & scl_prev;
   assign start_det = scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_det  = scl_s & scl_prev & ~sda_prev & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// Write-only I2C responder with a small host register bank.
// Accepted bytes land in rx_data; STATUS tracks hit/overrun/busy/full.
module i2c_slave
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h2A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       En,
   input  logic       RW,
   input  logic [1:0] ADDR,
   input  logic [7:0] DataIn,
   output logic [7:0] DataOut,
   input  logic       SCL,
   input  logic       iSDA,
   output logic       oSDA,
   output logic       rx_valid
);

   state_t     state_q;
   state_t     state_d;
   logic [2:0] cnt;
   logic [7:0] shreg;
   logic [7:0] byte_nxt;
   logic [7:0] rx_data;
   logic [6:0] own_addr;
   logic       ack_en;
   logic       ack_on;
   logic       rx_full;
   logic       overrun;
   logic       busy;
   logic       addr_hit;
   logic       sda_s;
   logic       scl_rise;
   logic       scl_fall;
   logic       start_det;
   logic       stop_det;
   logic       byte_done;
   logic       match;
   logic       accept;
   logic       rd_rx;
   logic       rd_st;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl       (SCL),
      .sda       (iSDA),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign byte_nxt  = {shreg[6:0], sda_s};
   assign byte_done = scl_rise && (cnt == 3'd7) &&
                      (state_q == S_ADDR || state_q == S_DATA);
   assign match     = (byte_nxt[7:1] == own_addr) && !byte_nxt[0] && ack_en;
   assign accept    = byte_done && (state_q == S_DATA) && !start_det && !stop_det;
   assign rd_rx     = En && RW && (ADDR == REG_RX_DATA);
   assign rd_st     = En && RW && (ADDR == REG_STATUS);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (start_det) begin
         state_d = S_ADDR;
      end else if (stop_det) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_ADDR:     if (byte_done) state_d = match ? S_ADDR_ACK : S_IGNORE;
            S_DATA:     if (byte_done) state_d = S_DATA_ACK;
            S_ADDR_ACK,
            S_DATA_ACK: if (scl_fall && ack_on) state_d = S_DATA;
            default:    state_d = state_q;
         endcase
      end
   end

   // ack_on marks the 9th-bit window; the ack_en gate only applies to data
   always_comb begin
      oSDA = ack_on & ((state_q == S_ADDR_ACK) |
                       ((state_q == S_DATA_ACK) & ack_en));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         shreg    <= '0;
         rx_data  <= '0;
         rx_valid <= 1'b0;
         ack_on   <= 1'b0;
         rx_full  <= 1'b0;
         overrun  <= 1'b0;
         busy     <= 1'b0;
         addr_hit <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (rd_rx) rx_full <= 1'b0;
         if (rd_st) overrun <= 1'b0;
         if (start_det) begin
            cnt      <= '0;
            ack_on   <= 1'b0;
            busy     <= 1'b1;
            addr_hit <= 1'b0;
         end else if (stop_det) begin
            cnt    <= '0;
            ack_on <= 1'b0;
            busy   <= 1'b0;
         end else begin
            unique case (state_q)
               S_ADDR, S_DATA: begin
                  if (scl_rise) begin
                     shreg <= byte_nxt;
                     cnt   <= cnt + 3'd1;
                  end
                  if (byte_done && state_q == S_ADDR && match) addr_hit <= 1'b1;
                  if (accept) begin
                     rx_data  <= byte_nxt;
                     rx_valid <= 1'b1;
                     rx_full  <= 1'b1;
                     if (rx_full) overrun <= 1'b1;
                  end
               end
               S_ADDR_ACK, S_DATA_ACK: if (scl_fall) ack_on <= ~ack_on;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         own_addr <= DEV_ADDR;
         ack_en   <= 1'b1;
         DataOut  <= '0;
      end else if (En) begin
         if (RW) begin
            unique case (ADDR)
               REG_OWN_ADDR: DataOut <= {1'b0, own_addr};
               REG_RX_DATA:  DataOut <= rx_data;
               REG_STATUS:   DataOut <= {4'b0, addr_hit, overrun, busy, rx_full};
               REG_CTRL:     DataOut <= {7'b0, ack_en};
            endcase
         end else begin
            if (ADDR == REG_OWN_ADDR) own_addr <= DataIn[6:0];
            if (ADDR == REG_CTRL)     ack_en   <= DataIn[0];
         end
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench: bit-banged I2C master plus host register accesses.
module tb_i2c_slave;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       En = 1'b0;
   logic       RW = 1'b0;
   logic [1:0] ADDR = 2'b00;
   logic [7:0] DataIn = 8'h00;
   logic [7:0] DataOut;
   logic       SCL = 1'b1;
   logic       iSDA = 1'b1;
   logic       oSDA;
   logic       rx_valid;

   int checks = 0;
   int failures = 0;
   int rv_cnt = 0;
   int os_cnt = 0;

   i2c_slave dut (
      .clk      (clk),
      .rst      (rst),
      .En       (En),
      .RW       (RW),
      .ADDR     (ADDR),
      .DataIn   (DataIn),
      .DataOut  (DataOut),
      .SCL      (SCL),
      .iSDA     (iSDA),
      .oSDA     (oSDA),
      .rx_valid (rx_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rx_valid === 1'b1) rv_cnt <= rv_cnt + 1;
      if (oSDA === 1'b1)     os_cnt <= os_cnt + 1;
   end

   task automatic check(input string tag, input logic [7:0] obs,
                        input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wq();
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic i2c_start();
      SCL = 1'b1; iSDA = 1'b1; wq();
      iSDA = 1'b0; wq();
      SCL = 1'b0; wq();
   endtask

   task automatic i2c_stop();
      iSDA = 1'b0; wq();
      SCL = 1'b1; wq();
      iSDA = 1'b1; wq(); wq();
   endtask

   task automatic send_bit(input logic b);
      iSDA = b; wq();
      SCL = 1'b1; wq(); wq();
      SCL = 1'b0; wq();
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
   endtask

   task automatic ack_slot(output logic a);
      iSDA = 1'b1; wq();
      SCL = 1'b1; wq();
      a = oSDA; wq();
      SCL = 1'b0; wq();
   endtask

   task automatic xfer(input logic [6:0] a, input logic [7:0] d,
                       output logic aa, output logic ad);
      i2c_start();
      send_byte({a, 1'b0});
      ack_slot(aa);
      send_byte(d);
      ack_slot(ad);
      i2c_stop();
   endtask

   task automatic host_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      En = 1'b1; RW = 1'b0; ADDR = a; DataIn = d;
      @(negedge clk);
      En = 1'b0;
   endtask

   task automatic host_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      En = 1'b1; RW = 1'b1; ADDR = a;
      @(negedge clk);
      En = 1'b0;
      d = DataOut;
   endtask

   initial begin
      logic [7:0] rd;
      logic       aa, ad;
      int         rv0, os0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_osda", {7'b0, oSDA}, 8'h00);
      check("rst_rxvalid", {7'b0, rx_valid}, 8'h00);
      check("rst_dataout", DataOut, 8'h00);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      host_read(2'b00, rd); check("rst_own_addr", rd, 8'h2A);
      host_read(2'b10, rd); check("rst_status", rd, 8'h00);
      host_read(2'b11, rd); check("rst_ctrl", rd, 8'h01);

      // default address, one data byte
      rv0 = rv_cnt;
      xfer(7'h2A, 8'hC3, aa, ad);
      check("t1_addr_ack", {7'b0, aa}, 8'h01);
      check("t1_data_ack", {7'b0, ad}, 8'h01);
      check("t1_rxvalid_cnt", 8'(rv_cnt - rv0), 8'h01);
      host_read(2'b10, rd); check("t1_status", rd, 8'h09);
      host_read(2'b01, rd); check("t1_rx_data", rd, 8'hC3);
      host_read(2'b10, rd); check("t1_status_after", rd, 8'h08);

      // foreign address is ignored
      rv0 = rv_cnt; os0 = os_cnt;
      xfer(7'h15, 8'h77, aa, ad);
      check("t2_addr_ack", {7'b0, aa}, 8'h00);
      check("t2_data_ack", {7'b0, ad}, 8'h00);
      check("t2_osda_cycles", 8'(os_cnt - os0), 8'h00);
      check("t2_rxvalid_cnt", 8'(rv_cnt - rv0), 8'h00);
      host_read(2'b10, rd); check("t2_status", rd, 8'h00);

      // reprogrammed own address
      host_write(2'b00, 8'h15);
      xfer(7'h15, 8'h5A, aa, ad);
      check("t3_addr_ack", {7'b0, aa}, 8'h01);
      check("t3_data_ack", {7'b0, ad}, 8'h01);
      host_read(2'b01, rd); check("t3_rx_data", rd, 8'h5A);

      // overrun on two unread bytes
      xfer(7'h15, 8'h11, aa, ad);
      xfer(7'h15, 8'h22, aa, ad);
      host_read(2'b10, rd); check("t4_status_ovr", rd, 8'h0D);
      host_read(2'b01, rd); check("t4_rx_data", rd, 8'h22);
      host_read(2'b10, rd); check("t4_status_clr", rd, 8'h08);

      // ack disabled: matching address still ignored
      host_write(2'b11, 8'h00);
      rv0 = rv_cnt; os0 = os_cnt;
      i2c_start();
      send_byte({7'h15, 1'b0});
      ack_slot(aa);
      check("t5_state_ignore", 8'(dut.state_q), 8'(5));
      send_byte(8'h99);
      ack_slot(ad);
      i2c_stop();
      check("t5_addr_ack", {7'b0, aa}, 8'h00);
      check("t5_data_ack", {7'b0, ad}, 8'h00);
      check("t5_osda_cycles", 8'(os_cnt - os0), 8'h00);
      check("t5_rxvalid_cnt", 8'(rv_cnt - rv0), 8'h00);
      host_read(2'b10, rd); check("t5_status", rd, 8'h00);
      host_write(2'b11, 8'h01);

      // reset in the middle of the data byte
      host_read(2'b00, rd); check("t6_own_before", rd, 8'h15);
      i2c_start();
      send_byte({7'h15, 1'b0});
      ack_slot(aa);
      check("t6_addr_ack", {7'b0, aa}, 8'h01);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      iSDA = 1'b1; wq(); SCL = 1'b1; wq();
      rst = 1'b1;
      #1;
      check("t6_rst_osda", {7'b0, oSDA}, 8'h00);
      check("t6_rst_rxvalid", {7'b0, rx_valid}, 8'h00);
      check("t6_rst_dataout", DataOut, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      SCL = 1'b1; iSDA = 1'b1; wq(); wq();
      host_read(2'b00, rd); check("t6_own_reset", rd, 8'h2A);
      host_read(2'b10, rd); check("t6_status_reset", rd, 8'h00);
      host_read(2'b11, rd); check("t6_ctrl_reset", rd, 8'h01);
      host_read(2'b01, rd); check("t6_rx_reset", rd, 8'h00);
      rv0 = rv_cnt;
      xfer(7'h2A, 8'hA5, aa, ad);
      check("t6_post_addr_ack", {7'b0, aa}, 8'h01);
      check("t6_post_data_ack", {7'b0, ad}, 8'h01);
      check("t6_post_rxvalid", 8'(rv_cnt - rv0), 8'h01);
      host_read(2'b01, rd); check("t6_post_rx_data", rd, 8'hA5);

      // partial byte at STOP is dropped
      rv0 = rv_cnt;
      i2c_start();
      send_byte({7'h2A, 1'b0});
      ack_slot(aa);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      i2c_stop();
      check("t7_rxvalid_cnt", 8'(rv_cnt - rv0), 8'h00);
      host_read(2'b01, rd); check("t7_rx_data", rd, 8'hA5);
      host_read(2'b10, rd); check("t7_status", rd, 8'h08);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
